// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg -- shared definitions for the two-requester register-bank arbiter.
//   state_t      : arbiter FSM encoding (IDLE, ACCESS, DONE)
//   REG_ARB_N    : default bank data width
//   REG_ARB_AW   : default bank address width
package reg_arb_pkg;

  localparam int REG_ARB_N  = 8;
  localparam int REG_ARB_AW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_arb_pick.sv
// reg_arb_pick -- combinational winner selection between two requesters.
// Ports:
//   req0, req1 : pending requests
//   ptr        : requester that wins when both are pending
//   gnt        : winner id (0 or 1); 0 when nobody requests
module reg_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ptr;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter -- arbitrates two requesters onto one shared register bank.
// Each access takes IDLE -> ACCESS -> DONE: the winner's request is latched
// in IDLE, the bank strobe (read or write) fires in ACCESS, and the winner's
// done pulses in DONE together with the read result.
//
// Handshake: a requester raises req with we/addr/in stable and holds it until
// it sees its done pulse; the arbiter samples req only in IDLE, so anything
// the requester changes after being latched is ignored. A req still high in
// IDLE after its done is a new access.
//
// Build option: define REG_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 always wins contention.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req0/req1          : access requests
//   we0/we1            : 1 = write, 0 = read
//   addr0/addr1        : bank addresses
//   in0/in1            : write data
//   done0/done1        : one-cycle completion pulses
//   rdata              : read result, valid with done, held otherwise
//   read/write         : bank strobes
//   addr/in            : bank address and write data (latched copy)
//   out                : bank read data, valid the cycle after read
//   dbg_state          : current FSM state for observation
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N  = REG_ARB_N,
  parameter int AW = REG_ARB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [N-1:0]  in0,
  input  logic [N-1:0]  in1,
  output logic          done0,
  output logic          done1,
  output logic [N-1:0]  rdata,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [N-1:0]  in,
  input  logic [N-1:0]  out,
  output state_t        dbg_state
);

  state_t        state_q;
  state_t        state_d;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  in_q;
  logic [N-1:0]  rdata_q;
  logic          gnt;
  logic          ptr;
  logic          any_req;
  logic          take;
  logic          rd_done;

  assign any_req = req0 | req1;
  assign take    = (state_q == IDLE) && any_req;
  assign rd_done = (state_q == DONE) && !we_q;

  reg_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .gnt  (gnt)
  );

`ifdef REG_ARB_RR_EN
  // ptr names the requester that wins the next contention: after each grant
  // it moves to the other requester.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (take) begin
      ptr_q <= ~gnt;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    read  = 1'b0;
    write = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    case (state_q)
      ACCESS: begin
        read  = !we_q;
        write = we_q;
      end
      DONE: begin
        done0 = !win_q;
        done1 = win_q;
      end
      default: ;
    endcase
  end

  // Request latch and read-result register
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      in_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        win_q  <= gnt;
        we_q   <= gnt ? we1   : we0;
        addr_q <= gnt ? addr1 : addr0;
        in_q   <= gnt ? in1   : in0;
      end
      if (rd_done) begin
        rdata_q <= out;
      end
    end
  end

  // The bank answers during DONE, so pass it straight through while done is
  // high and hold the captured copy from then on.
  assign rdata     = rd_done ? out : rdata_q;
  assign addr      = addr_q;
  assign in        = in_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_arbiter.sv
module tb_reg_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;

  // Clock / reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [N-1:0]  in0, in1;
  logic          done0, done1, read, write;
  logic [N-1:0]  rdata;
  logic [AW-1:0] addr;
  logic [N-1:0]  in;
  logic [N-1:0]  out;
  state_t        dbg_state;

  int checks;
  int failures;

  reg_arbiter #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .in0       (in0),
    .in1       (in1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .in        (in),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // Register bank model: writes on the strobe edge, read data registered.
  logic [N-1:0] mem [8];
  always @(posedge clk) begin
    if (write) mem[addr] <= in;
    if (read)  out <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bank strobes are exclusive and at most one done pulses, every cycle.
  always @(negedge clk) begin
    check("strobe_excl", {31'd0, read && write}, 32'd0);
    check("done_excl", {31'd0, done0 && done1}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a done pulse is visible (bounded); n = cycles taken.
  task automatic wait_done(output int n, output logic g1, output logic ok);
    n  = 0;
    g1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      step();
      n++;
      if (done0 || done1) begin
        ok = 1'b1;
        g1 = done1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int       n;
    logic     g1;
    logic     ok;
    logic [3:0] exp_gnt;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    out   = '0;
    rst   = 1'b1;
    req0  = 1'b0; req1 = 1'b0;
    we0   = 1'b0; we1  = 1'b0;
    addr0 = '0;   addr1 = '0;
    in0   = '0;   in1   = '0;

    // Reset state
    step();
    step();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_write", 32'(write), 32'd0);
    check("rst_read",  32'(read), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr",  32'(addr), 32'd0);
    check("rst_in",    32'(in), 32'd0);
    rst = 1'b0;
    step();

    // Write A5 to address 3 from requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; in0 = 8'hA5;
    step();
    check("wr_write", 32'(write), 32'd1);
    check("wr_read",  32'(read), 32'd0);
    check("wr_addr",  32'(addr), 32'd3);
    check("wr_in",    32'(in), 32'hA5);
    check("wr_early_done", 32'(done0), 32'd0);
    step();
    check("wr_done0", 32'(done0), 32'd1);
    check("wr_done1", 32'(done1), 32'd0);
    check("wr_strobe_off", 32'(write), 32'd0);
    check("wr_rdata_hold", 32'(rdata), 32'd0);
    req0 = 1'b0;
    step();
    check("wr_idle", 32'(dbg_state), 32'(IDLE));
    check("wr_done_end", 32'(done0), 32'd0);

    // Read back from requester 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
    step();
    check("rd_read",  32'(read), 32'd1);
    check("rd_write", 32'(write), 32'd0);
    check("rd_addr",  32'(addr), 32'd3);
    step();
    check("rd_done1", 32'(done1), 32'd1);
    check("rd_done0", 32'(done0), 32'd0);
    check("rd_rdata", 32'(rdata), 32'hA5);
    req1 = 1'b0;
    step();
    check("rd_rdata_hold", 32'(rdata), 32'hA5);
    check("rd_done_end", 32'(done1), 32'd0);

    // Contention: both held high for four accesses
`ifdef REG_ARB_RR_EN
    exp_gnt = 4'b1010;
`else
    exp_gnt = 4'b0000;
`endif
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; in0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; in1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      wait_done(n, g1, ok);
      check($sformatf("cont_seen%0d", k), 32'(ok), 32'd1);
      check($sformatf("cont_gnt%0d", k), 32'(g1), 32'(exp_gnt[k]));
      check($sformatf("cont_lat%0d", k), n, (k == 0) ? 32'd2 : 32'd3);
    end
    // The held-back requester is served once requester 0 lets go.
    req0 = 1'b0;
    wait_done(n, g1, ok);
    check("pend_seen", 32'(ok), 32'd1);
    check("pend_gnt",  32'(g1), 32'd1);
    check("pend_lat",  n, 32'd3);
    req1 = 1'b0;
    step();
    check("cont_idle", 32'(dbg_state), 32'(IDLE));
    check("mem1", 32'(mem[1]), 32'h11);
    check("mem2", 32'(mem[2]), 32'h22);

    // Reset in the middle of a write to address 5
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; in0 = 8'h5A;
    step();
    check("ab_write", 32'(write), 32'd1);
    check("ab_addr",  32'(addr), 32'd5);
    rst = 1'b1;
    step();
    check("ab_state", 32'(dbg_state), 32'(IDLE));
    check("ab_write_off", 32'(write), 32'd0);
    check("ab_done0", 32'(done0), 32'd0);
    check("ab_rdata", 32'(rdata), 32'd0);
    check("ab_addr0", 32'(addr), 32'd0);
    check("ab_in0",   32'(in), 32'd0);
    step();
    check("ab_rst_override", 32'(dbg_state), 32'(IDLE));
    rst  = 1'b0;
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ab_nodone%0d", i), 32'(done0 | done1), 32'd0);
    end

    // Address change during ACCESS is ignored
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    step();
    check("lat_read", 32'(read), 32'd1);
    check("lat_addr", 32'(addr), 32'd2);
    addr0 = 3'd6; we0 = 1'b1; in0 = 8'hFF;
    step();
    check("lat_addr_done", 32'(addr), 32'd2);
    check("lat_done0", 32'(done0), 32'd1);
    check("lat_rdata", 32'(rdata), 32'h22);
    req0 = 1'b0;
    step();
    check("lat_rdata_hold", 32'(rdata), 32'h22);
    check("lat_mem6", 32'(mem[6]), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
